// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty compare.
// Host writes land in shadow registers that are copied to the active set only at a period wrap.
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,   // legal range 1 .. 2**ADDR_W-1
  parameter int ADDR_W   = 3
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                cs,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                enable,
  output logic [CHANNELS-1:0] clkout,
  output logic                sync
);

  localparam logic [ADDR_W-1:0] PERIOD_ADDR = ADDR_W'(CHANNELS);
  localparam logic [WIDTH-1:0]  ALL_ONES    = '1;

  logic [WIDTH-1:0]    r_sh_duty  [CHANNELS];
  logic [WIDTH-1:0]    r_act_duty [CHANNELS];
  logic [WIDTH-1:0]    r_sh_period;
  logic [WIDTH-1:0]    r_act_period;
  logic [WIDTH-1:0]    r_cnt;
  logic [CHANNELS-1:0] r_clkout;
  logic                r_sync;

  logic                w_wrap;
  logic [WIDTH-1:0]    w_cnt_next;
  logic [CHANNELS-1:0] w_pwm;

  // On a wrap edge the compare uses the shadow duty being loaded, so the new
  // period's first cycle already reflects the new setting.
  always_comb begin
    w_wrap     = (r_cnt == r_act_period);
    w_cnt_next = w_wrap ? '0 : r_cnt + WIDTH'(1);
    w_pwm      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_pwm[i] = w_cnt_next < (w_wrap ? r_sh_duty[i] : r_act_duty[i]);
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_sh_duty[i]  <= '0;
        r_act_duty[i] <= '0;
      end
      r_sh_period  <= ALL_ONES;
      r_act_period <= ALL_ONES;
      r_cnt        <= ALL_ONES;
      r_clkout     <= '0;
      r_sync       <= 1'b0;
    end else begin
      if (enable) begin
        r_cnt    <= w_cnt_next;
        r_clkout <= w_pwm;
        r_sync   <= w_wrap;
        if (w_wrap) begin
          r_act_period <= r_sh_period;
          for (int i = 0; i < CHANNELS; i++) begin
            r_act_duty[i] <= r_sh_duty[i];
          end
        end
      end else begin
        // Parking cnt on the period forces a wrap on the first enabled edge.
        r_cnt    <= r_act_period;
        r_clkout <= '0;
        r_sync   <= 1'b0;
      end

      // Non-blocking writes: a wrap on this same edge still copies the old shadow.
      if (cs) begin
        if (addr == PERIOD_ADDR) begin
          r_sh_period <= wdata;
        end
        for (int i = 0; i < CHANNELS; i++) begin
          if (addr == ADDR_W'(i)) begin
            r_sh_duty[i] <= wdata;
          end
        end
      end
    end
  end

  assign clkout = r_clkout;
  assign sync   = r_sync;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi (WIDTH=8, CHANNELS=4, ADDR_W=3).
// Expected {sync, clkout[3:0]} values are queued per edge and compared after the edge.
module tb_pwm_multi;

  logic       clk;
  logic       reset;
  logic       cs;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       enable;
  logic [3:0] clkout;
  logic       sync;

  logic [4:0] exp_q[$];
  logic [4:0] exp_v;
  logic [4:0] got_v;
  int         n_tests;
  int         n_fail;

  pwm_multi #(.WIDTH(8), .CHANNELS(4), .ADDR_W(3)) dut (
    .clkin  (clk),
    .reset  (reset),
    .cs     (cs),
    .addr   (addr),
    .wdata  (wdata),
    .enable (enable),
    .clkout (clkout),
    .sync   (sync)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic do_reset();
    reset  = 1'b1;
    cs     = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    reset  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    got_v = {sync, clkout};
    n_tests++;
    if (got_v !== 5'b0) begin
      n_fail++; $display("FAIL reset_state got=%b exp=%b", got_v, 5'b0);
    end
    wr(3'd0, 8'd255);
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({(k == 0), 4'b0001});
      @(posedge clk); #1;
      got_v = {sync, clkout}; exp_v = exp_q.pop_front(); n_tests++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL pre_reset_run k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
    end
    #3 reset = 1'b1;
    #1;
    got_v = {sync, clkout}; n_tests++;
    if (got_v !== 5'b0) begin
      n_fail++; $display("FAIL async_reset got=%b exp=%b", got_v, 5'b0);
    end
    @(posedge clk); #1;
    got_v = {sync, clkout}; n_tests++;
    if (got_v !== 5'b0) begin
      n_fail++; $display("FAIL reset_held got=%b exp=%b", got_v, 5'b0);
    end
    reset = 1'b0;
    // defaults: period 255, duty 0 -> outputs low, sync every 256 edges
    for (int k = 0; k < 513; k++) begin
      exp_q.push_back({(k % 256 == 0), 4'b0000});
      @(posedge clk); #1;
      got_v = {sync, clkout}; exp_v = exp_q.pop_front(); n_tests++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL defaults k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
    end
  endtask

  task automatic test_basic();
    int ph;
    do_reset();
    wr(3'd4, 8'd7);
    wr(3'd0, 8'd3);
    got_v = {sync, clkout}; n_tests++;
    if (got_v !== 5'b0) begin
      n_fail++; $display("FAIL basic_idle got=%b exp=%b", got_v, 5'b0);
    end
    enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      ph = k % 8;
      exp_q.push_back({(ph == 0), 3'b000, (ph < 3)});
      @(posedge clk); #1;
      got_v = {sync, clkout}; exp_v = exp_q.pop_front(); n_tests++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL basic k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
    end
  endtask

  task automatic test_boundary();
    int ph;
    do_reset();
    wr(3'd4, 8'd7);
    wr(3'd0, 8'd3);
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd8);
    wr(3'd3, 8'd255);
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ph = k % 8;
      exp_q.push_back({(ph == 0), 1'b1, 1'b1, 1'b0, (ph < 3)});
      @(posedge clk); #1;
      got_v = {sync, clkout}; exp_v = exp_q.pop_front(); n_tests++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL boundary k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
    end
  endtask

  task automatic test_glitch_free();
    int ph;
    logic c1;
    do_reset();
    wr(3'd4, 8'd7);
    wr(3'd0, 8'd3);
    wr(3'd1, 8'd2);
    wr(3'd2, 8'd8);
    wr(3'd3, 8'd255);
    enable = 1'b1;
    for (int k = 0; k < 64; k++) begin
      cs = 1'b0;
      if (k == 4)  begin cs = 1'b1; addr = 3'd1; wdata = 8'd6;  end
      if (k == 27) begin cs = 1'b1; addr = 3'd4; wdata = 8'd15; end
      ph = (k < 32) ? (k % 8) : ((k - 32) % 16);
      c1 = (k < 8) ? (ph < 2) : (ph < 6);
      exp_q.push_back({(ph == 0), 1'b1, (ph < 8), c1, (ph < 3)});
      @(posedge clk); #1;
      got_v = {sync, clkout}; exp_v = exp_q.pop_front(); n_tests++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL glitch_free k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
    end
    cs = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ph;
    logic c0;
    do_reset();
    wr(3'd4, 8'd7);
    wr(3'd0, 8'd3);
    enable = 1'b1;
    // writes on wrap edges 8 and 16 only take effect at the following wrap
    for (int k = 0; k < 36; k++) begin
      cs = 1'b0;
      if (k == 8)  begin cs = 1'b1; addr = 3'd0; wdata = 8'd5; end
      if (k == 16) begin cs = 1'b1; addr = 3'd4; wdata = 8'd3; end
      ph = (k < 24) ? (k % 8) : ((k - 24) % 4);
      c0 = (k < 16) ? (ph < 3) : (ph < 5);
      exp_q.push_back({(ph == 0), 3'b000, c0});
      @(posedge clk); #1;
      got_v = {sync, clkout}; exp_v = exp_q.pop_front(); n_tests++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL wrap_write k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
    end
    cs = 1'b0;
  endtask

  task automatic test_ignored_addr();
    int ph;
    do_reset();
    wr(3'd4, 8'd7);
    wr(3'd0, 8'd3);
    wr(3'd5, 8'd2);
    wr(3'd6, 8'd2);
    wr(3'd7, 8'd2);
    enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      cs = 1'b0;
      if (k >= 2 && k <= 4) begin
        cs = 1'b1; addr = 3'(k + 3); wdata = 8'd1;
      end
      ph = k % 8;
      exp_q.push_back({(ph == 0), 3'b000, (ph < 3)});
      @(posedge clk); #1;
      got_v = {sync, clkout}; exp_v = exp_q.pop_front(); n_tests++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL ignored_addr k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
    end
    cs = 1'b0;
  endtask

  task automatic test_enable_drop();
    int ph;
    logic en;
    do_reset();
    wr(3'd4, 8'd7);
    wr(3'd0, 8'd3);
    wr(3'd2, 8'd8);
    for (int k = 0; k < 26; k++) begin
      en = !(k >= 11 && k < 14);
      enable = en;
      cs = 1'b0;
      if (k == 12) begin cs = 1'b1; addr = 3'd0; wdata = 8'd1; end
      ph = (k < 11) ? (k % 8) : ((k - 14) % 8);
      if (en)
        exp_q.push_back({(ph == 0), 1'b0, 1'b1, 1'b0, ((k < 11) ? (ph < 3) : (ph < 1))});
      else
        exp_q.push_back(5'b0);
      @(posedge clk); #1;
      got_v = {sync, clkout}; exp_v = exp_q.pop_front(); n_tests++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL enable_drop k=%0d got=%b exp=%b", k, got_v, exp_v);
      end
    end
    cs = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    cs      = 1'b0;
    enable  = 1'b0;
    addr    = 3'd0;
    wdata   = 8'd0;
    #1;
    test_reset();
    test_basic();
    test_boundary();
    test_glitch_free();
    test_back_to_back();
    test_ignored_addr();
    test_enable_drop();
    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
